// File: rtl/ext_port_arbiter.sv
// ---------------------------------------------------------------------------
// ext_port_arbiter
//
// Shares the SDRAM controller's single Ext port between NCLIENTS masters
// (memory adapter, scroll/offset engine, blitter, ...). One transaction is in
// flight at a time. Each client sees a request/ready handshake identical to
// the Ext port itself.
//
// Arbitration:
//   default                 : round-robin, scanning from the client after the
//                             last one served (client 0 wins first after reset)
//   EXT_ARB_FIXED_PRIO_EN   : fixed priority, lowest index wins
//
// Parameters:
//   NCLIENTS  number of client ports (2..8)
//   ADDR_W    Ext word address width
//   DATA_W    Ext data width (multiple of 8)
//   MASK_W    byte-mask width, derived as DATA_W/8
//
// Ports:
//   PixelClk2     clock, rising edge
//   Reset         asynchronous active-high reset
//   CliReq        per-client request, held until that client's CliReady
//   CliOP         per-client op (1 = write, 0 = read)
//   CliAddr       flattened addresses, client k at [k*ADDR_W +: ADDR_W]
//   CliDataWrite  flattened write data
//   CliDataMask   flattened byte masks (1 = byte masked)
//   CliReady      one-cycle completion pulse per client
//   CliDataRead   per-client read data, held until that client's next read
//   Grant         one-hot owner of the in-flight transaction, 0 when idle
//   ExtAddr/ExtDataWrite/ExtDataMask/ExtOP/ExtReq   towards SDRAM
//   ExtReady/ExtDataRead                            from SDRAM
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module ext_port_arbiter #(
    parameter int  NCLIENTS = 3,
    parameter int  ADDR_W   = 24,
    parameter int  DATA_W   = 16,
    localparam int MASK_W   = DATA_W / 8
) (
    input  logic                         PixelClk2,
    input  logic                         Reset,
    input  logic [NCLIENTS-1:0]          CliReq,
    input  logic [NCLIENTS-1:0]          CliOP,
    input  logic [NCLIENTS*ADDR_W-1:0]   CliAddr,
    input  logic [NCLIENTS*DATA_W-1:0]   CliDataWrite,
    input  logic [NCLIENTS*MASK_W-1:0]   CliDataMask,
    output logic [NCLIENTS-1:0]          CliReady,
    output logic [NCLIENTS*DATA_W-1:0]   CliDataRead,
    output logic [NCLIENTS-1:0]          Grant,
    output logic [ADDR_W-1:0]            ExtAddr,
    output logic [DATA_W-1:0]            ExtDataWrite,
    output logic [MASK_W-1:0]            ExtDataMask,
    output logic                         ExtOP,
    output logic                         ExtReq,
    input  logic                         ExtReady,
    input  logic [DATA_W-1:0]            ExtDataRead
);

    localparam int IDX_W = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NCLIENTS - 1);

    // Elaboration-time parameter sanity checks.
    if (NCLIENTS < 2 || NCLIENTS > 8) begin : g_bad_nclients
        $error("ext_port_arbiter: NCLIENTS must be in 2..8");
    end
    if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
        $error("ext_port_arbiter: DATA_W must be a non-zero multiple of 8");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RELEASE
    } state_e;

    // Unpacked views of the flattened client buses.
    logic [ADDR_W-1:0] cli_addr  [NCLIENTS];
    logic [DATA_W-1:0] cli_wdata [NCLIENTS];
    logic [MASK_W-1:0] cli_mask  [NCLIENTS];

    state_e                state_q,      state_d;
    logic [IDX_W-1:0]      cur_idx_q,    cur_idx_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [NCLIENTS-1:0]   grant_q,      grant_d;
    logic [NCLIENTS-1:0]   cli_ready_q,  cli_ready_d;
    logic [DATA_W-1:0]     cli_rdata_q   [NCLIENTS];
    logic [DATA_W-1:0]     cli_rdata_d   [NCLIENTS];
    logic [ADDR_W-1:0]     ext_addr_q,   ext_addr_d;
    logic [DATA_W-1:0]     ext_wdata_q,  ext_wdata_d;
    logic [MASK_W-1:0]     ext_mask_q,   ext_mask_d;
    logic                  ext_op_q,     ext_op_d;
    logic                  ext_req_q,    ext_req_d;

    logic [IDX_W-1:0]      win_idx;

    for (genvar k = 0; k < NCLIENTS; k++) begin : g_client
        assign cli_addr[k]  = CliAddr[k*ADDR_W +: ADDR_W];
        assign cli_wdata[k] = CliDataWrite[k*DATA_W +: DATA_W];
        assign cli_mask[k]  = CliDataMask[k*MASK_W +: MASK_W];
        assign CliDataRead[k*DATA_W +: DATA_W] = cli_rdata_q[k];
    end

    // -----------------------------------------------------------------------
    // Winner selection. Only consulted in IDLE when some request is pending.
    // -----------------------------------------------------------------------
`ifdef EXT_ARB_FIXED_PRIO_EN
    always_comb begin
        win_idx = '0;
        // Descending scan: the lowest pending index is written last and wins.
        for (int j = NCLIENTS - 1; j >= 0; j--) begin
            if (CliReq[j]) win_idx = IDX_W'(j);
        end
    end
`else
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path infers a latch.
        win_idx = '0;
        // Two descending scans: clients at or below LastGrant form the
        // low-priority tail of the round; clients above LastGrant come first
        // and therefore overwrite any tail choice. Within each group the
        // lowest index wins, giving the order LastGrant+1 ... wrapping to 0.
        for (int j = NCLIENTS - 1; j >= 0; j--) begin
            if (CliReq[j] && (IDX_W'(j) <= last_grant_q)) win_idx = IDX_W'(j);
        end
        for (int j = NCLIENTS - 1; j >= 0; j--) begin
            if (CliReq[j] && (IDX_W'(j) > last_grant_q)) win_idx = IDX_W'(j);
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cur_idx_d    = cur_idx_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cli_ready_d  = cli_ready_q;
        cli_rdata_d  = cli_rdata_q;
        ext_addr_d   = ext_addr_q;
        ext_wdata_d  = ext_wdata_q;
        ext_mask_d   = ext_mask_q;
        ext_op_d     = ext_op_q;
        ext_req_d    = ext_req_q;

        unique case (state_q)
            S_IDLE: begin
                // A stray ExtReady here is deliberately ignored.
                if (|CliReq) begin
                    cur_idx_d   = win_idx;
                    grant_d     = NCLIENTS'(1) << win_idx;
                    ext_addr_d  = cli_addr[win_idx];
                    ext_wdata_d = cli_wdata[win_idx];
                    ext_mask_d  = cli_mask[win_idx];
                    ext_op_d    = CliOP[win_idx];
                    ext_req_d   = 1'b1;
                    state_d     = S_BUSY;
                end
            end

            S_BUSY: begin
                // Ext* stay frozen; client-side changes are not looked at.
                if (ExtReady) begin
                    ext_req_d    = 1'b0;
                    cli_ready_d  = grant_q;
                    last_grant_d = cur_idx_q;
                    if (!ext_op_q) cli_rdata_d[cur_idx_q] = ExtDataRead;
                    state_d      = S_RELEASE;
                end
            end

            S_RELEASE: begin
                // The client drops CliReq at the edge it samples CliReady,
                // so IDLE never arbitrates on a stale request.
                cli_ready_d = '0;
                grant_d     = '0;
                state_d     = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge PixelClk2 or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            cur_idx_q    <= '0;
            last_grant_q <= LAST_RST;
            grant_q      <= '0;
            cli_ready_q  <= '0;
            // NOTE: the per-client read-data array is a visible output with a
            // defined reset value, so it is cleared like any other register.
            for (int k = 0; k < NCLIENTS; k++) cli_rdata_q[k] <= '0;
            ext_addr_q   <= '0;
            ext_wdata_q  <= '0;
            ext_mask_q   <= '0;
            ext_op_q     <= 1'b0;
            ext_req_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_idx_q    <= cur_idx_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cli_ready_q  <= cli_ready_d;
            cli_rdata_q  <= cli_rdata_d;
            ext_addr_q   <= ext_addr_d;
            ext_wdata_q  <= ext_wdata_d;
            ext_mask_q   <= ext_mask_d;
            ext_op_q     <= ext_op_d;
            ext_req_q    <= ext_req_d;
        end
    end

    assign CliReady     = cli_ready_q;
    assign Grant        = grant_q;
    assign ExtAddr      = ext_addr_q;
    assign ExtDataWrite = ext_wdata_q;
    assign ExtDataMask  = ext_mask_q;
    assign ExtOP        = ext_op_q;
    assign ExtReq       = ext_req_q;

endmodule

// File: tb/tb_ext_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ext_port_arbiter
//
// Directed scoreboard bench for ext_port_arbiter (3 clients, 24-bit address,
// 16-bit data). Each transaction's expected Ext-side request and client-side
// completion are queued before stimulus; a monitor pops and compares on every
// new ExtReq and every CliReady pulse. A small SDRAM model answers requests
// after a programmable latency with data derived from the address.
// Define EXT_ARB_FIXED_PRIO_EN to check the fixed-priority build.
// ---------------------------------------------------------------------------
module tb_ext_port_arbiter;

    localparam int NC = 3;
    localparam int AW = 24;
    localparam int DW = 16;
    localparam int MW = DW / 8;

    typedef struct {
        int          cli;
        logic [AW-1:0] addr;
        logic        op;
        logic [DW-1:0] wd;
        logic [MW-1:0] mask;
        logic [DW-1:0] rd;   // CliDataRead[cli] required right after completion
    } txn_t;

    logic              clk;
    logic              Reset;
    logic [NC-1:0]     CliReq;
    logic [NC-1:0]     CliOP;
    logic [NC*AW-1:0]  CliAddr;
    logic [NC*DW-1:0]  CliDataWrite;
    logic [NC*MW-1:0]  CliDataMask;
    logic [NC-1:0]     CliReady;
    logic [NC*DW-1:0]  CliDataRead;
    logic [NC-1:0]     Grant;
    logic [AW-1:0]     ExtAddr;
    logic [DW-1:0]     ExtDataWrite;
    logic [MW-1:0]     ExtDataMask;
    logic              ExtOP;
    logic              ExtReq;
    logic              ExtReady;
    logic [DW-1:0]     ExtDataRead;

    int   total = 0;
    int   bad = 0;
    int   onehot_err = 0;
    int   sdram_lat = 3;
    txn_t req_q[$];
    txn_t done_q[$];

    ext_port_arbiter #(.NCLIENTS(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .PixelClk2   (clk),
        .Reset       (Reset),
        .CliReq      (CliReq),
        .CliOP       (CliOP),
        .CliAddr     (CliAddr),
        .CliDataWrite(CliDataWrite),
        .CliDataMask (CliDataMask),
        .CliReady    (CliReady),
        .CliDataRead (CliDataRead),
        .Grant       (Grant),
        .ExtAddr     (ExtAddr),
        .ExtDataWrite(ExtDataWrite),
        .ExtDataMask (ExtDataMask),
        .ExtOP       (ExtOP),
        .ExtReq      (ExtReq),
        .ExtReady    (ExtReady),
        .ExtDataRead (ExtDataRead)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // SDRAM read data: one hand-picked word, otherwise address + 0x1111.
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        if (a == 24'h012345) return 16'hBEEF;
        return a[15:0] + 16'h1111;
    endfunction

    function automatic txn_t mk(input int k, input logic op, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd, input logic [MW-1:0] m,
                                input logic [DW-1:0] rd);
        txn_t t;
        t.cli = k; t.addr = a; t.op = op; t.wd = wd; t.mask = m; t.rd = rd;
        return t;
    endfunction

    task automatic expect_txn(input txn_t t);
        req_q.push_back(t);
        done_q.push_back(t);
    endtask

    // One client transaction: raise request, wait (bounded) for CliReady, drop.
    task automatic serve(input int k, input logic op, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [MW-1:0] m);
        logic seen;
        CliOP[k]                 = op;
        CliAddr[k*AW +: AW]      = a;
        CliDataWrite[k*DW +: DW] = wd;
        CliDataMask[k*MW +: MW]  = m;
        CliReq[k]                = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            seen = CliReady[k];
        end
        check($sformatf("ready_seen_c%0d", k), 64'(seen), 64'd1);
        CliReq[k] = 1'b0;
    endtask

    // SDRAM model: answers each request after sdram_lat cycles unless reset.
    initial begin
        int n;
        ExtReady    = 1'b0;
        ExtDataRead = '0;
        forever begin
            @(negedge clk);
            if (ExtReq && !Reset) begin
                n = 0;
                while (n < sdram_lat && !Reset) begin
                    @(negedge clk);
                    n++;
                end
                if (!Reset && ExtReq) begin
                    ExtReady    = 1'b1;
                    ExtDataRead = mem_f(ExtAddr);
                    @(negedge clk);
                    ExtReady    = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin
        txn_t t;
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!$onehot0(Grant)) onehot_err++;
            if (ExtReq && !$onehot(Grant)) onehot_err++;
            if (ExtReq && !req_prev) begin
                check("req_expected", 64'(req_q.size() != 0), 64'd1);
                if (req_q.size() != 0) begin
                    t = req_q.pop_front();
                    check("grant", 64'(Grant), 64'(NC'(1) << t.cli));
                    check("ext_addr", 64'(ExtAddr), 64'(t.addr));
                    check("ext_op", 64'(ExtOP), 64'(t.op));
                    check("ext_wdata", 64'(ExtDataWrite), 64'(t.wd));
                    check("ext_mask", 64'(ExtDataMask), 64'(t.mask));
                end
            end
            req_prev = ExtReq;
            if (|CliReady) begin
                check("done_expected", 64'(done_q.size() != 0), 64'd1);
                if (done_q.size() != 0) begin
                    t = done_q.pop_front();
                    check("cli_ready", 64'(CliReady), 64'(NC'(1) << t.cli));
                    check("cli_rdata", 64'(CliDataRead[t.cli*DW +: DW]), 64'(t.rd));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic seen;
        Reset        = 1'b1;
        CliReq       = '0;
        CliOP        = '0;
        CliAddr      = '0;
        CliDataWrite = '0;
        CliDataMask  = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_ext_req",   64'(ExtReq), 64'd0);
        check("rst_grant",     64'(Grant), 64'd0);
        check("rst_cli_ready", 64'(CliReady), 64'd0);
        check("rst_ext_addr",  64'(ExtAddr), 64'd0);
        check("rst_ext_misc",  64'({ExtOP, ExtDataWrite, ExtDataMask}), 64'd0);
        check("rst_cli_rdata", 64'(CliDataRead), 64'd0);
        Reset = 1'b0;
        @(negedge clk);

        // 1: single read by client 1, 5-cycle SDRAM latency.
        sdram_lat = 5;
        expect_txn(mk(1, 1'b0, 24'h012345, 16'h0, 2'b00, 16'hBEEF));
        CliOP[1] = 1'b0;
        CliAddr[1*AW +: AW] = 24'h012345;
        CliReq[1] = 1'b1;
        @(negedge clk);
        check("t1_req_latency", 64'(ExtReq), 64'd1);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = CliReady[1];
        end
        check("t1_ready_seen", 64'(seen), 64'd1);
        check("t1_grant_release", 64'(Grant), 64'b010);
        CliReq[1] = 1'b0;
        @(negedge clk);
        check("t1_grant_idle", 64'(Grant), 64'd0);
        check("t1_ready_pulse", 64'(CliReady), 64'd0);

        // 2: all three request at once after reset -> 0,1,2.
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        @(negedge clk);
        sdram_lat = 3;
        expect_txn(mk(0, 1'b0, 24'h000100, 16'h0, 2'b00, 16'h1211));
        expect_txn(mk(1, 1'b0, 24'h000200, 16'h0, 2'b00, 16'h1311));
        expect_txn(mk(2, 1'b0, 24'h000300, 16'h0, 2'b00, 16'h1411));
        fork
            serve(0, 1'b0, 24'h000100, 16'h0, 2'b00);
            serve(1, 1'b0, 24'h000200, 16'h0, 2'b00);
            serve(2, 1'b0, 24'h000300, 16'h0, 2'b00);
        join
        @(negedge clk);

        // 3: client 1 served, then 0 and 2 pending, 2 re-requests.
        expect_txn(mk(1, 1'b0, 24'h000210, 16'h0, 2'b00, 16'h1321));
        serve(1, 1'b0, 24'h000210, 16'h0, 2'b00);
        @(negedge clk);
`ifdef EXT_ARB_FIXED_PRIO_EN
        expect_txn(mk(0, 1'b0, 24'h000400, 16'h0, 2'b00, 16'h1511));
        expect_txn(mk(2, 1'b0, 24'h000500, 16'h0, 2'b00, 16'h1611));
        expect_txn(mk(2, 1'b0, 24'h000600, 16'h0, 2'b00, 16'h1711));
`else
        expect_txn(mk(2, 1'b0, 24'h000500, 16'h0, 2'b00, 16'h1611));
        expect_txn(mk(0, 1'b0, 24'h000400, 16'h0, 2'b00, 16'h1511));
        expect_txn(mk(2, 1'b0, 24'h000600, 16'h0, 2'b00, 16'h1711));
`endif
        fork
            serve(0, 1'b0, 24'h000400, 16'h0, 2'b00);
            begin
                serve(2, 1'b0, 24'h000500, 16'h0, 2'b00);
                serve(2, 1'b0, 24'h000600, 16'h0, 2'b00);
            end
        join
        @(negedge clk);

        // 4: masked write by client 0; its read data must stay 0x1511.
        expect_txn(mk(0, 1'b1, 24'h000700, 16'hA55A, 2'b10, 16'h1511));
        serve(0, 1'b1, 24'h000700, 16'hA55A, 2'b10);
        @(negedge clk);

        // 5: reset while client 2 is in BUSY; re-granted with same address.
        sdram_lat = 10;
        req_q.push_back(mk(2, 1'b0, 24'h000800, 16'h0, 2'b00, 16'h1911));
        expect_txn(mk(2, 1'b0, 24'h000800, 16'h0, 2'b00, 16'h1911));
        fork
            serve(2, 1'b0, 24'h000800, 16'h0, 2'b00);
            begin
                seen = 1'b0;
                for (int c = 0; c < 50 && !seen; c++) begin
                    @(negedge clk);
                    seen = ExtReq;
                end
                check("t5_busy_reached", 64'(seen), 64'd1);
                repeat (2) @(negedge clk);
                #2 Reset = 1'b1;
                #1;
                check("t5_async_ext_req", 64'(ExtReq), 64'd0);
                check("t5_async_grant",   64'(Grant), 64'd0);
                check("t5_async_ready",   64'(CliReady), 64'd0);
                check("t5_async_rdata",   64'(CliDataRead), 64'd0);
                repeat (2) @(negedge clk);
                sdram_lat = 3;
                Reset = 1'b0;
            end
        join
        @(negedge clk);

        // Stray ExtReady while idle: nothing may happen.
        ExtReady    = 1'b1;
        ExtDataRead = 16'hDEAD;
        @(negedge clk);
        ExtReady    = 1'b0;
        check("stray_ready",   64'(CliReady), 64'd0);
        check("stray_grant",   64'(Grant), 64'd0);
        check("stray_ext_req", 64'(ExtReq), 64'd0);
        @(negedge clk);
        check("stray_rdata2",  64'(CliDataRead[2*DW +: DW]), 64'h1911);
        check("stray_ready2",  64'(CliReady), 64'd0);

        // 6: client 0 issues back-to-back while client 2 waits.
`ifdef EXT_ARB_FIXED_PRIO_EN
        expect_txn(mk(0, 1'b0, 24'h000900, 16'h0, 2'b00, 16'h1A11));
        expect_txn(mk(0, 1'b0, 24'h000A00, 16'h0, 2'b00, 16'h1B11));
        expect_txn(mk(2, 1'b0, 24'h000B00, 16'h0, 2'b00, 16'h1C11));
`else
        expect_txn(mk(0, 1'b0, 24'h000900, 16'h0, 2'b00, 16'h1A11));
        expect_txn(mk(2, 1'b0, 24'h000B00, 16'h0, 2'b00, 16'h1C11));
        expect_txn(mk(0, 1'b0, 24'h000A00, 16'h0, 2'b00, 16'h1B11));
`endif
        fork
            begin
                serve(0, 1'b0, 24'h000900, 16'h0, 2'b00);
                serve(0, 1'b0, 24'h000A00, 16'h0, 2'b00);
            end
            serve(2, 1'b0, 24'h000B00, 16'h0, 2'b00);
        join
        repeat (5) @(negedge clk);

        check("req_queue_empty",  64'(req_q.size()), 64'd0);
        check("done_queue_empty", 64'(done_q.size()), 64'd0);
        check("grant_onehot",     64'(onehot_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
